// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the FSM state encoding, line-level constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // Zero-extended words give the same XOR reduction, so one width covers 5..9 bits.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] word,
                                       input logic                     odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular word buffer for the UART transmitter: DEPTH entries (power of 2),
// wrapping read/write pointers, registered fill level, full/empty flags.
module uart_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rp_r;
  logic [PTR_W-1:0] wp_r;
  logic [LVL_W-1:0] level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rp_r];
  assign level     = level_r;

  // Storage array; contents are only meaningful below the fill level, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wp_r] <= wdata;
    end
  end

  // Pointers and fill level; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_r    <= {PTR_W{1'b0}};
      wp_r    <= {PTR_W{1'b0}};
      level_r <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wp_r <= wp_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rp_r <= rp_r + PTR_W'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVL_W'(1'b1);
        2'b01:   level_r <= level_r - LVL_W'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end, clock divider and framing FSM, LSB first.
// Define UART_PARITY_EN to insert a parity bit after the data bits (sense from PARITY_ODD).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  CDIV        = 10,
  parameter int  DATA_BITS   = 8,
  parameter int  STOP_BITS   = 2,
  parameter int  BUFFER_SIZE = 4,
  parameter int  PARITY_ODD  = 0,
  localparam int LVL_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic [LVL_W-1:0]     level
);

  localparam int DIV_W   = $clog2(CDIV);
  localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CDIV - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  uart_state_e          state_r, state_s;
  logic [DIV_W-1:0]     div_r, div_s;
  logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 tx_r, tx_s;
  logic                 bit_end_s;
  logic                 load_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
`ifdef UART_PARITY_EN
  logic                 par_r, par_s;
`endif

  uart_fifo #(
    .DEPTH (BUFFER_SIZE),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid),
    .wdata (data),
    .pop   (pop_s),
    .rdata (head_s),
    .level (level),
    .full  (full_s),
    .empty (empty_s)
  );

  assign bit_end_s = (div_r == DIV_LAST);
  assign ready     = ~full_s;
  assign busy      = (state_r != ST_IDLE) | ~empty_s;
  assign tx        = tx_r;

  // Next-state logic; load_s pops the head word and starts a frame on the same edge.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    tx_s      = tx_r;
    load_s    = 1'b0;
    pop_s     = 1'b0;
`ifdef UART_PARITY_EN
    par_s     = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          load_s = 1'b1;
        end else begin
          tx_s  = TX_IDLE;
          div_s = {DIV_W{1'b0}};
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s   = ST_DATA;
          div_s     = {DIV_W{1'b0}};
          bit_cnt_s = {CNT_W{1'b0}};
          tx_s      = shift_r[0];
        end else begin
          div_s = div_r + DIV_W'(1'b1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          div_s = {DIV_W{1'b0}};
          if (bit_cnt_r == DATA_LAST) begin
`ifdef UART_PARITY_EN
            state_s = ST_PARITY;
            tx_s    = par_r;
`else
            state_s   = ST_STOP;
            bit_cnt_s = {CNT_W{1'b0}};
            tx_s      = STOP_BIT;
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1'b1);
            shift_s   = shift_r >> 1;
            tx_s      = shift_r[1];
          end
        end else begin
          div_s = div_r + DIV_W'(1'b1);
        end
      end
      ST_PARITY: begin
`ifdef UART_PARITY_EN
        if (bit_end_s) begin
          state_s   = ST_STOP;
          div_s     = {DIV_W{1'b0}};
          bit_cnt_s = {CNT_W{1'b0}};
          tx_s      = STOP_BIT;
        end else begin
          div_s = div_r + DIV_W'(1'b1);
        end
`else
        state_s = ST_IDLE;
        div_s   = {DIV_W{1'b0}};
        tx_s    = TX_IDLE;
`endif
      end
      ST_STOP: begin
        if (bit_end_s) begin
          div_s = {DIV_W{1'b0}};
          if (bit_cnt_r == STOP_LAST) begin
            if (!empty_s) begin
              load_s = 1'b1;
            end else begin
              state_s = ST_IDLE;
              tx_s    = TX_IDLE;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1'b1);
          end
        end else begin
          div_s = div_r + DIV_W'(1'b1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        div_s     = {DIV_W{1'b0}};
        bit_cnt_s = {CNT_W{1'b0}};
        tx_s      = TX_IDLE;
      end
    endcase

    if (load_s) begin
      pop_s     = 1'b1;
      state_s   = ST_START;
      div_s     = {DIV_W{1'b0}};
      bit_cnt_s = {CNT_W{1'b0}};
      shift_s   = head_s;
      tx_s      = START_BIT;
`ifdef UART_PARITY_EN
      par_s     = calc_parity(MAX_DATA_BITS'(head_s), 1'(PARITY_ODD));
`endif
    end else begin
      pop_s = 1'b0;
    end
  end

  // Framing state; reset drops any frame in progress and returns the line to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      div_r     <= {DIV_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      tx_r      <= TX_IDLE;
`ifdef UART_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      tx_r      <= tx_s;
`ifdef UART_PARITY_EN
      par_r     <= par_s;
`endif
    end
  end

endmodule
